// File: rtl/vme_bus_requester_if.sv
// Signal bundle for the VME bus requester: CPU-side request strobes, the sensed
// VME arbitration lines, and the registered arbitration drives it produces.
interface vme_bus_requester_if;
    logic       request_vme;
    logic       cpu_as;
    logic       vme_bgin;
    logic       vme_bbsy_in;
    logic       vme_as_in;
    logic       vme_br_in;
    logic       vme_br;
    logic       vme_bbsy;
    logic       vme_bgout;
    logic       bus_acquired;
    logic [2:0] state;

    modport master (
        input  request_vme, cpu_as, vme_bgin, vme_bbsy_in, vme_as_in, vme_br_in,
        output vme_br, vme_bbsy, vme_bgout, bus_acquired, state
    );

    modport slave (
        output request_vme, cpu_as, vme_bgin, vme_bbsy_in, vme_as_in, vme_br_in,
        input  vme_br, vme_bbsy, vme_bgout, bus_acquired, state
    );
endinterface

// File: rtl/vme_bus_requester.sv
// VME bus requester: arbitrates for the VME bus on behalf of the CPU, holds BBSY for a
// minimum tenure, and passes the daisy-chained grant down when it is not requesting.
module vme_bus_requester #(
    parameter int BBSY_MIN_CYCLES    = 4,
    parameter bit RELEASE_ON_REQUEST = 1'b0
) (
    input logic                 clock,
    input logic                 reset,
    vme_bus_requester_if.master bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQUEST = 3'd1,
        GRANTED = 3'd2,
        OWNED   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(BBSY_MIN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic       withdrawn_q, withdrawn_d;
    logic       br_q, br_d;
    logic       bbsy_q, bbsy_d;
    logic       bgout_q, bgout_d;
    logic       acquired_q, acquired_d;
    logic [3:0] sync1, sync2;
    logic       bgin_s, bbsy_s, as_s, br_s;
    logic       release_cond;

    assign {br_s, as_s, bbsy_s, bgin_s} = sync2;

    // Lines sensed from the backplane are asynchronous; reset them to the inactive level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= {bus.vme_br_in, bus.vme_as_in, bus.vme_bbsy_in, bus.vme_bgin};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= 4'd0;
            withdrawn_q <= 1'b0;
            br_q        <= 1'b1;
            bbsy_q      <= 1'b1;
            bgout_q     <= 1'b1;
            acquired_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            withdrawn_q <= withdrawn_d;
            br_q        <= br_d;
            bbsy_q      <= bbsy_d;
            bgout_q     <= bgout_d;
            acquired_q  <= acquired_d;
        end
    end

    // Release-on-request keeps the bus across CPU cycles until another master asks for it.
    assign release_cond = RELEASE_ON_REQUEST ? (!br_s && bus.cpu_as)
                                             : (bus.request_vme && bus.cpu_as);

    always_comb begin
        state_d     = state_q;
        withdrawn_d = withdrawn_q;
        hold_d      = (hold_q != 4'd0) ? hold_q - 4'd1 : 4'd0;
        case (state_q)
            IDLE: begin
                withdrawn_d = 1'b0;
                if (!bus.request_vme && !bus.cpu_as && bgout_q)
                    state_d = REQUEST;
            end
            REQUEST: begin
                if (bus.request_vme)
                    withdrawn_d = 1'b1;
                if (!bgin_s && bbsy_s) begin
                    state_d = GRANTED;
                    hold_d  = HOLD_LOAD;
                end
            end
            GRANTED: begin
                if (withdrawn_q)
                    state_d = RELEASE;
                else if (as_s)
                    state_d = OWNED;
            end
            OWNED: begin
                if (release_cond)
                    state_d = RELEASE;
            end
            RELEASE: begin
                if (hold_q == 4'd0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Drives are decoded from the next state so every output comes straight off a flop.
        br_d       = (state_d != REQUEST);
        bbsy_d     = !(state_d inside {GRANTED, OWNED, RELEASE});
        acquired_d = (state_d != OWNED);
        bgout_d    = (state_d == IDLE) ? bgin_s : 1'b1;
    end

    assign bus.vme_br       = br_q;
    assign bus.vme_bbsy     = bbsy_q;
    assign bus.vme_bgout    = bgout_q;
    assign bus.bus_acquired = acquired_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_vme_bus_requester.sv
// Bench for vme_bus_requester: a release-when-done and a release-on-request instance
// share directed stimulus and are checked against a tenure-level model every cycle.
module tb_vme_bus_requester;
    localparam int MIN_CYCLES = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic request_vme = 1'b1;
    logic cpu_as      = 1'b1;
    logic bgin        = 1'b1;
    logic bbsy_in     = 1'b1;
    logic as_in       = 1'b1;
    logic br_in       = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    vme_bus_requester_if bus0 ();
    vme_bus_requester_if bus1 ();

    assign bus0.request_vme = request_vme;
    assign bus0.cpu_as      = cpu_as;
    assign bus0.vme_bgin    = bgin;
    assign bus0.vme_bbsy_in = bbsy_in;
    assign bus0.vme_as_in   = as_in;
    assign bus0.vme_br_in   = br_in;
    assign bus1.request_vme = request_vme;
    assign bus1.cpu_as      = cpu_as;
    assign bus1.vme_bgin    = bgin;
    assign bus1.vme_bbsy_in = bbsy_in;
    assign bus1.vme_as_in   = as_in;
    assign bus1.vme_br_in   = br_in;

    vme_bus_requester #(.BBSY_MIN_CYCLES(MIN_CYCLES), .RELEASE_ON_REQUEST(1'b0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    vme_bus_requester #(.BBSY_MIN_CYCLES(MIN_CYCLES), .RELEASE_ON_REQUEST(1'b1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clock = ~clock;

    // Tenure model: time since the grant edge decides when BBSY may drop.
    typedef struct packed {
        logic [2:0] code;
        logic [4:0] since_grant;
        logic       withdrawn;
        logic       br;
        logic       bbsy;
        logic       bgout;
        logic       acquired;
    } model_t;

    localparam model_t MODEL_RESET = '{code: 3'd0, since_grant: 5'd31, withdrawn: 1'b0,
                                       br: 1'b1, bbsy: 1'b1, bgout: 1'b1, acquired: 1'b1};

    logic [3:0] seen_a, seen_b;
    model_t     model0, model1;

    function automatic model_t step(model_t m, logic [3:0] seen, logic req, logic cas, bit ror);
        model_t n;
        logic   bg, busy, prev_as, other_br;
        n        = m;
        bg       = seen[0];
        busy     = seen[1];
        prev_as  = seen[2];
        other_br = seen[3];
        n.since_grant = (m.since_grant == 5'd31) ? 5'd31 : m.since_grant + 5'd1;
        case (m.code)
            3'd0: begin
                n.withdrawn = 1'b0;
                if (!req && !cas && m.bgout) n.code = 3'd1;
            end
            3'd1: begin
                if (req) n.withdrawn = 1'b1;
                if (!bg && busy) begin
                    n.code        = 3'd2;
                    n.since_grant = 5'd0;
                end
            end
            3'd2: begin
                if (m.withdrawn) n.code = 3'd4;
                else if (prev_as) n.code = 3'd3;
            end
            3'd3: begin
                if (cas && (ror ? !other_br : req)) n.code = 3'd4;
            end
            3'd4: begin
                if (int'(m.since_grant) + 1 >= MIN_CYCLES) n.code = 3'd0;
            end
            default: n.code = 3'd0;
        endcase
        n.br       = (n.code != 3'd1);
        n.bbsy     = !(n.code == 3'd2 || n.code == 3'd3 || n.code == 3'd4);
        n.acquired = (n.code != 3'd3);
        n.bgout    = (n.code == 3'd0) ? bg : 1'b1;
        return n;
    endfunction

    function automatic logic [6:0] pack_model(model_t m);
        return {m.code, m.br, m.bbsy, m.bgout, m.acquired};
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            seen_a <= 4'hF;
            seen_b <= 4'hF;
            model0 <= MODEL_RESET;
            model1 <= MODEL_RESET;
        end else begin
            seen_a <= {br_in, as_in, bbsy_in, bgin};
            seen_b <= seen_a;
            model0 <= step(model0, seen_b, request_vme, cpu_as, 1'b0);
            model1 <= step(model1, seen_b, request_vme, cpu_as, 1'b1);
        end
    end

    task automatic check_output(input string name, input logic [6:0] actual, input logic [6:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%b required=%b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_state(input string name, input logic [2:0] actual, input logic [2:0] expected);
        check_output(name, 7'(actual), 7'(expected));
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        check_output(name, 7'(actual), 7'(expected));
    endtask

    // Packed as {state, br, bbsy, bgout, bus_acquired}.
    always @(negedge clock) begin
        if (!reset) begin
            check_output("model dut0", {bus0.state, bus0.vme_br, bus0.vme_bbsy, bus0.vme_bgout,
                                        bus0.bus_acquired}, pack_model(model0));
            check_output("model dut1", {bus1.state, bus1.vme_br, bus1.vme_bbsy, bus1.vme_bgout,
                                        bus1.bus_acquired}, pack_model(model1));
        end
    end

    task automatic apply_stimulus(input logic req, input logic cas, input logic bg,
                                  input logic busy, input logic pas, input logic obr);
        request_vme = req;
        cpu_as      = cas;
        bgin        = bg;
        bbsy_in     = busy;
        as_in       = pas;
        br_in       = obr;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        apply_stimulus(1, 1, 1, 1, 1, 1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check_state("reset dut0 state", bus0.state, 3'd0);
        check_bit("reset dut0 br", bus0.vme_br, 1'b1);
        check_bit("reset dut0 bbsy", bus0.vme_bbsy, 1'b1);
        check_bit("reset dut0 bgout", bus0.vme_bgout, 1'b1);
        check_bit("reset dut0 acquired", bus0.bus_acquired, 1'b1);

        // Basic tenure followed by an early release that still honours the BBSY minimum.
        apply_stimulus(0, 0, 1, 1, 1, 1);
        tick(1);
        check_state("tenure request state", bus0.state, 3'd1);
        check_bit("tenure request br", bus0.vme_br, 1'b0);
        apply_stimulus(0, 0, 0, 1, 1, 1);
        tick(2);
        check_state("tenure grant in sync", bus0.state, 3'd1);
        tick(1);
        check_state("tenure granted state", bus0.state, 3'd2);
        check_bit("tenure granted bbsy", bus0.vme_bbsy, 1'b0);
        check_bit("tenure granted br", bus0.vme_br, 1'b1);
        tick(1);
        check_state("tenure owned state", bus0.state, 3'd3);
        check_bit("tenure owned acquired", bus0.bus_acquired, 1'b0);
        apply_stimulus(1, 1, 1, 1, 1, 1);
        tick(1);
        check_state("short release state", bus0.state, 3'd4);
        check_bit("short release acquired", bus0.bus_acquired, 1'b1);
        check_bit("short release bbsy", bus0.vme_bbsy, 1'b0);
        check_state("ror keeps owned", bus1.state, 3'd3);
        tick(1);
        check_bit("short hold bbsy", bus0.vme_bbsy, 1'b0);
        tick(1);
        check_state("short idle state", bus0.state, 3'd0);
        check_bit("short idle bbsy", bus0.vme_bbsy, 1'b1);

        // Release-on-request instance keeps the bus across CPU cycles until BR is seen.
        apply_stimulus(1, 0, 1, 1, 1, 1);
        tick(2);
        apply_stimulus(1, 1, 1, 1, 1, 1);
        tick(1);
        apply_stimulus(1, 0, 1, 1, 1, 1);
        tick(2);
        check_state("ror back-to-back state", bus1.state, 3'd3);
        check_bit("ror back-to-back bbsy", bus1.vme_bbsy, 1'b0);
        apply_stimulus(1, 1, 1, 1, 1, 0);
        tick(2);
        check_state("ror br in sync", bus1.state, 3'd3);
        tick(1);
        check_state("ror release state", bus1.state, 3'd4);
        check_bit("ror release acquired", bus1.bus_acquired, 1'b1);
        tick(1);
        check_state("ror idle state", bus1.state, 3'd0);
        check_bit("ror idle bbsy", bus1.vme_bbsy, 1'b1);

        // Daisy chain: grant passes down, and a local request waits for it to clear.
        apply_stimulus(1, 1, 0, 1, 1, 1);
        tick(2);
        check_bit("chain bgout early", bus0.vme_bgout, 1'b1);
        tick(1);
        check_bit("chain bgout passed", bus0.vme_bgout, 1'b0);
        apply_stimulus(0, 0, 0, 1, 1, 1);
        tick(3);
        check_state("chain blocked state", bus0.state, 3'd0);
        check_bit("chain blocked br", bus0.vme_br, 1'b1);
        apply_stimulus(0, 0, 1, 1, 1, 1);
        tick(3);
        check_bit("chain bgout cleared", bus0.vme_bgout, 1'b1);
        check_bit("chain still no br", bus0.vme_br, 1'b1);
        tick(1);
        check_state("chain request state", bus0.state, 3'd1);
        check_bit("chain request br", bus0.vme_br, 1'b0);

        // Withdrawn request: grant is taken then dropped without ever acquiring the bus.
        apply_stimulus(1, 1, 1, 1, 1, 1);
        tick(2);
        check_bit("withdraw keeps br", bus0.vme_br, 1'b0);
        apply_stimulus(1, 1, 0, 1, 1, 1);
        tick(3);
        check_state("withdraw granted", bus0.state, 3'd2);
        apply_stimulus(0, 0, 1, 1, 1, 1);
        tick(1);
        check_state("withdraw release", bus0.state, 3'd4);
        check_bit("withdraw acquired", bus0.bus_acquired, 1'b1);
        tick(2);
        check_state("release ignores request", bus0.state, 3'd4);
        tick(1);
        check_state("withdraw idle", bus0.state, 3'd0);
        check_bit("withdraw idle bbsy", bus0.vme_bbsy, 1'b1);
        tick(1);
        check_state("request after idle", bus0.state, 3'd1);

        // Previous master still has AS asserted: stay GRANTED until it lets go.
        apply_stimulus(0, 0, 0, 1, 0, 1);
        tick(3);
        check_state("busy granted", bus0.state, 3'd2);
        tick(3);
        check_state("busy still granted", bus0.state, 3'd2);
        check_bit("busy not acquired", bus0.bus_acquired, 1'b1);
        apply_stimulus(0, 0, 1, 1, 1, 1);
        tick(2);
        check_state("busy as in sync", bus0.state, 3'd2);
        tick(1);
        check_state("busy owned", bus0.state, 3'd3);
        check_bit("busy acquired", bus0.bus_acquired, 1'b0);
        check_bit("busy dut1 acquired", bus1.bus_acquired, 1'b0);

        // Reset while owning the bus drops every drive before the next edge.
        #2;
        reset = 1'b1;
        #1;
        check_state("midreset dut0 state", bus0.state, 3'd0);
        check_bit("midreset dut0 br", bus0.vme_br, 1'b1);
        check_bit("midreset dut0 bbsy", bus0.vme_bbsy, 1'b1);
        check_bit("midreset dut0 bgout", bus0.vme_bgout, 1'b1);
        check_bit("midreset dut0 acquired", bus0.bus_acquired, 1'b1);
        check_state("midreset dut1 state", bus1.state, 3'd0);
        check_bit("midreset dut1 bbsy", bus1.vme_bbsy, 1'b1);
        apply_stimulus(1, 1, 1, 1, 1, 1);
        tick(2);
        reset = 1'b0;
        tick(2);
        check_state("post reset dut0", bus0.state, 3'd0);
        check_state("post reset dut1", bus1.state, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
